// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply core.
//   state_e        : controller states (IDLE, LOAD, RUN, DONE)
//   acc_w_default  : default accumulator width for a given element width / dimension
//   elem_lsb       : LSB position of element (row, col) in a row-major flat vector
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A full-width product plus log2(N) bits of dot-product growth plus one
    // guard bit, so a single C = A x B never wraps in either signedness.
    function automatic int acc_w_default(input int data_w, input int n);
        return 2 * data_w + $clog2(n) + 1;
    endfunction

    function automatic int elem_lsb(input int row, input int col, input int n, input int w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/systolic_matmul_core_pe.sv
// One processing element of the output-stationary systolic grid.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : zero the accumulator on this edge (product is discarded)
//   signed_i      : 1 = operands are two's complement, 0 = unsigned
//   a_i / a_o     : A operand in from the left, registered copy out to the right
//   b_i / b_o     : B operand in from above, registered copy out below
//   acc_o         : accumulator value as it will be after this edge
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = acc_w_default(DATA_W, 4)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]    prod_ext;

    always_comb begin
        a_d = a_i;
        b_d = b_i;
        // The low 2*DATA_W bits of a product are the same for signed and
        // unsigned operands once each operand is extended the right way, so
        // one multiplier serves both modes.
        a_ext    = {{DATA_W{signed_i & a_i[DATA_W-1]}}, a_i};
        b_ext    = {{DATA_W{signed_i & b_i[DATA_W-1]}}, b_i};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W - 2 * DATA_W){signed_i & prod[2*DATA_W-1]}}, prod};
        acc_d    = clr_i ? '0 : acc_q + prod_ext;
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    // The next-state value is exported so the final product of a run lands in
    // the result register on the same edge that ends RUN.
    assign acc_o = acc_d;

endmodule

// File: rtl/systolic_matmul_core.sv
// N x N output-stationary systolic matrix multiplier: C = A x B or C += A x B.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i            : request; accepted only in IDLE or DONE
//   signed_i, acc_i    : operand signedness / accumulate mode, sampled at accept
//   mat_a_i, mat_b_i   : row-major flat operands, DATA_W bits per element
//   result_o           : row-major flat C, ACC_W bits per element, held between runs
//   busy_o             : high while the array is computing
//   done_o             : one-cycle pulse on the cycle result_o takes a new value
module systolic_matmul_core
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 4,
    parameter int ACC_W  = acc_w_default(DATA_W, N)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  acc_i,
    input  logic [N*N*DATA_W-1:0] mat_a_i,
    input  logic [N*N*DATA_W-1:0] mat_b_i,
    output logic [N*N*ACC_W-1:0]  result_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int MAT_W = N * N * DATA_W;
    localparam int RES_W = N * N * ACC_W;
    localparam int CNT_W = $clog2(3 * N - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3 * N - 3);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAT_W-1:0] a_cap_q, a_cap_d;
    logic [MAT_W-1:0] b_cap_q, b_cap_d;
    logic             signed_q, signed_d;
    logic             acc_mode_q, acc_mode_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic                  pe_clr;
    logic [DATA_W-1:0]     a_inj [N];
    logic [DATA_W-1:0]     b_inj [N];
    logic [DATA_W-1:0]     a_in  [N][N];
    logic [DATA_W-1:0]     b_in  [N][N];
    logic [DATA_W-1:0]     a_fwd [N][N];
    logic [DATA_W-1:0]     b_fwd [N][N];
    logic [ACC_W-1:0]      acc_nxt [N][N];
    logic [2*N*DATA_W-1:0] fwd_unused;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first, so branches that do
        // not mention a signal cannot infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_cap_d    = a_cap_q;
        b_cap_d    = b_cap_q;
        signed_d   = signed_q;
        acc_mode_d = acc_mode_q;
        result_d   = result_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = LOAD;
                    a_cap_d    = mat_a_i;
                    b_cap_d    = mat_b_i;
                    signed_d   = signed_i;
                    acc_mode_d = acc_i;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            result_d[elem_lsb(r, c, N, ACC_W) +: ACC_W] = acc_nxt[r][c];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    // NOTE: the operand and result registers are reset along with the control
    // state so result_o reads zero after reset and accumulate mode starts from a
    // known value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_cap_q    <= '0;
            b_cap_q    <= '0;
            signed_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_cap_q    <= a_cap_d;
            b_cap_q    <= b_cap_d;
            signed_q   <= signed_d;
            acc_mode_q <= acc_mode_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Accumulators are wiped on the LOAD edge unless this run accumulates.
    assign pe_clr = (state_q == LOAD) && !acc_mode_q;

    // ------------------------------------------------------------------
    // Skewed injection at the array edges: row r of A and column c of B are
    // delayed by r (resp. c) cycles by indexing the captured operands with
    // cnt - r. Outside RUN and outside each window zeros are fed, so the PE
    // stage registers are already flushed to zero by the time LOAD comes round.
    // ------------------------------------------------------------------
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
            a_inj[i] = '0;
            b_inj[i] = '0;
        end
        if (state_q == RUN) begin
            for (int i = 0; i < N; i++) begin
                k = int'(cnt_q) - i;
                if (k >= 0 && k < N) begin
                    a_inj[i] = a_cap_q[elem_lsb(i, k, N, DATA_W) +: DATA_W];
                    b_inj[i] = b_cap_q[elem_lsb(k, i, N, DATA_W) +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PE grid: A flows right, B flows down, C stays put.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign a_in[r][c] = a_inj[r];
            end else begin : g_a_chain
                assign a_in[r][c] = a_fwd[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_in[r][c] = b_inj[c];
            end else begin : g_b_chain
                assign b_in[r][c] = b_fwd[r-1][c];
            end

            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .clr_i    (pe_clr),
                .signed_i (signed_q),
                .a_i      (a_in[r][c]),
                .b_i      (b_in[r][c]),
                .a_o      (a_fwd[r][c]),
                .b_o      (b_fwd[r][c]),
                .acc_o    (acc_nxt[r][c])
            );
        end
    end

    // Operands leaving the right and bottom edges of the grid go nowhere.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            fwd_unused[i*DATA_W +: DATA_W]     = a_fwd[i][N-1];
            fwd_unused[(N+i)*DATA_W +: DATA_W] = b_fwd[N-1][i];
        end
    end

    assign result_o = result_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_systolic_matmul_core.sv
// Directed self-checking bench for systolic_matmul_core (N=4, DATA_W=4, ACC_W=11).
module tb_systolic_matmul_core;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 11;
    localparam int MW = N * N * DW;
    localparam int RW = N * N * AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sgn;
    logic          accm;
    logic [MW-1:0] mat_a;
    logic [MW-1:0] mat_b;
    logic [RW-1:0] result;
    logic          busy;
    logic          done;

    int tests_run    = 0;
    int tests_failed = 0;

    int arr_a [N*N] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15};
    int arr_b [N*N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15};
    int arr_i [N*N];

    always #5 clk = ~clk;

    systolic_matmul_core #(
        .N      (N),
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .signed_i (sgn),
        .acc_i    (accm),
        .mat_a_i  (mat_a),
        .mat_b_i  (mat_b),
        .result_o (result),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input int m [N*N]);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < N * N; i++) v[i*DW +: DW] = DW'(m[i]);
        return v;
    endfunction

    function automatic logic [AW-1:0] el(input logic [RW-1:0] v, input int r, input int c);
        return v[(r*N+c)*AW +: AW];
    endfunction

    // Plain matrix product in 32-bit integers, truncated to AW bits.
    function automatic logic [RW-1:0] ref_mm(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                             input logic s, input logic ac,
                                             input logic [RW-1:0] prev);
        logic [RW-1:0] res;
        logic [DW-1:0] ea, eb;
        int sum, va, vb;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sum = ac ? int'(prev[(r*N+c)*AW +: AW]) : 0;
                for (int k = 0; k < N; k++) begin
                    ea = a[(r*N+k)*DW +: DW];
                    eb = b[(k*N+c)*DW +: DW];
                    va = s ? int'($signed(ea)) : int'(ea);
                    vb = s ? int'($signed(eb)) : int'(eb);
                    sum += va * vb;
                end
                res[(r*N+c)*AW +: AW] = sum[AW-1:0];
            end
        end
        return res;
    endfunction

    // Called at a falling edge: present a request for one cycle, then scramble
    // the inputs so only the captured copy can produce the right answer.
    task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic s, input logic ac);
        mat_a = a;
        mat_b = b;
        sgn   = s;
        accm  = ac;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mat_a = ~a;
        mat_b = ~b;
        sgn   = ~s;
        accm  = ~ac;
    endtask

    // Starts one falling edge after the accept edge; returns the number of
    // rising edges after the accept edge at which done_o was seen, and the
    // number of sampled cycles with busy_o high. Bounded at 40 edges.
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = busy ? 1 : 0;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
            if (busy) busy_n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] m_a, m_b, m_i, m_f, m_one;
        logic [RW-1:0] exp_basic, exp_acc, exp_id, exp_neg4, exp_60, exp_v;
        int e, bz, dones;

        for (int i = 0; i < N * N; i++) arr_i[i] = (i % (N + 1) == 0) ? 1 : 0;
        m_a   = mk(arr_a);
        m_b   = mk(arr_b);
        m_i   = mk(arr_i);
        m_f   = '1;
        m_one = '0;
        for (int i = 0; i < N * N; i++) m_one[i*DW +: DW] = 4'h1;
        exp_neg4 = '0;
        exp_60   = '0;
        for (int i = 0; i < N * N; i++) begin
            exp_neg4[i*AW +: AW] = 11'h7FC;
            exp_60[i*AW +: AW]   = 11'd60;
        end
        exp_basic = ref_mm(m_a, m_b, 1'b0, 1'b0, '0);
        exp_acc   = ref_mm(m_a, m_b, 1'b0, 1'b1, exp_basic);
        exp_id    = ref_mm(m_i, m_b, 1'b0, 1'b0, '0);

        // ---------------- reset / idle ----------------
        rst_n = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        accm  = 1'b0;
        mat_a = '0;
        mat_b = '0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst_result", result, '0);
        check("rst_busy", RW'(busy), '0);
        check("rst_done", RW'(done), '0);
        start = 1'b0;
        rst_n = 1'b1;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("idle_no_activity", RW'(dones), '0);

        // ---------------- basic unsigned ----------------
        launch(m_a, m_b, 1'b0, 1'b0);
        wait_done(e, bz);
        check("basic_latency", RW'(e), RW'(11));
        check("basic_busy_cycles", RW'(bz), RW'(10));
        check("basic_c00", RW'(el(result, 0, 0)), RW'(89));
        check("basic_c33", RW'(el(result, 3, 3)), RW'(569));
        check("basic_full", result, exp_basic);
        @(negedge clk);
        check("done_one_cycle", RW'(done), '0);
        check("result_held", result, exp_basic);

        // ---------------- accumulate ----------------
        launch(m_a, m_b, 1'b0, 1'b1);
        wait_done(e, bz);
        check("acc_c00", RW'(el(result, 0, 0)), RW'(178));
        check("acc_c33", RW'(el(result, 3, 3)), RW'(1138));
        check("acc_full", result, exp_acc);

        // ---------------- identity ----------------
        launch(m_i, m_b, 1'b0, 1'b0);
        wait_done(e, bz);
        check("id_latency", RW'(e), RW'(11));
        check("id_busy_cycles", RW'(bz), RW'(10));
        check("id_c33", RW'(el(result, 3, 3)), RW'(15));
        check("id_full", result, exp_id);

        // ---------------- signed vs unsigned ----------------
        launch(m_f, m_one, 1'b1, 1'b0);
        wait_done(e, bz);
        check("signed_all_m4", result, exp_neg4);
        launch(m_f, m_one, 1'b0, 1'b0);
        wait_done(e, bz);
        check("unsigned_all_60", result, exp_60);

        // ---------------- start during RUN ----------------
        launch(m_a, m_b, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        mat_a = m_i;
        accm  = 1'b1;
        start = 1'b1;
        check("held_during_run", result, exp_60);
        @(negedge clk);
        start = 1'b0;
        wait_done(e, bz);
        check("hazard_latency", RW'(e + 6), RW'(11));
        check("hazard_result", result, exp_basic);
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("hazard_no_queue", RW'(dones), '0);

        // ---------------- back-to-back start in DONE ----------------
        launch(m_a, m_b, 1'b0, 1'b0);
        wait_done(e, bz);
        check("b2b_done_pulse", RW'(done), RW'(1));
        launch(m_i, m_b, 1'b0, 1'b0);
        wait_done(e, bz);
        check("b2b_latency", RW'(e), RW'(11));
        check("b2b_result", result, exp_id);

        // ---------------- reset at RUN cnt=4 ----------------
        launch(m_a, m_b, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_result", result, '0);
        check("midrun_rst_busy", RW'(busy), '0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_v = ref_mm(m_a, m_b, 1'b0, 1'b1, '0);
        launch(m_a, m_b, 1'b0, 1'b1);
        wait_done(e, bz);
        check("post_rst_latency", RW'(e), RW'(11));
        check("post_rst_acc_onto_zero", RW'(el(result, 0, 0)), RW'(89));
        check("post_rst_full", result, exp_v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
